// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the two-master bus arbiter: FSM state encoding,
// wait-counter width and the default acknowledge timeout.
// No ports; imported by bus_arbiter and bus_arbiter_rr.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    // Width of the acknowledge wait counter.
    localparam int CNT_W = 8;

    // Bus cycles a slave may take to acknowledge before the transfer aborts.
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
// Two-way round-robin pick. Pure combinational.
// Ports:
//   req_i        [1:0]  request vector, bit N = master N requesting
//   last_grant_i        master granted most recently
//   grant_o             master to grant (meaningful only when req_i != 0)
// -----------------------------------------------------------------------------
module bus_arbiter_rr
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o
);

    always_comb begin
        // On a tie the master that did not win last time goes first;
        // otherwise whichever single master is asking wins.
        if (req_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = req_i[1];
        end
    end

endmodule : bus_arbiter_rr

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Arbitrates two Wishbone-style masters onto one shared slave bus.
// IDLE/BUSY FSM with a registered grant, a last-grant pointer for
// round-robin fairness and an acknowledge wait counter that aborts a
// transfer with err after TIMEOUT cycles.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i               master N cycle, strobe, write enable
//   mN_addr_i/data_i/sel_i            master N address, write data, byte select
//   mN_data_o/ack_o/err_o             read data, done, timeout abort to master N
//   s_cyc_o/stb_o/we_o                cycle, strobe, write enable to slave
//   s_addr_o/data_o/sel_o             address, write data, select to slave
//   s_data_i/ack_i                    read data and acknowledge from slave
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [1:0]  req;
    logic        pick;
    logic        g_cyc, g_stb, g_we;
    logic [31:0] g_addr, g_data;
    logic [3:0]  g_sel;
    logic        out_busy;
    logic        g_active;
    logic        ack_hit;
    logic        timeout_hit;

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    bus_arbiter_rr u_rr (
        .req_i        (req),
        .last_grant_i (last_q),
        .grant_o      (pick)
    );

    // Granted master's request signals.
    always_comb begin
        if (grant_q) begin
            g_cyc  = m1_cyc_i;
            g_stb  = m1_stb_i;
            g_we   = m1_we_i;
            g_addr = m1_addr_i;
            g_data = m1_data_i;
            g_sel  = m1_sel_i;
        end else begin
            g_cyc  = m0_cyc_i;
            g_stb  = m0_stb_i;
            g_we   = m0_we_i;
            g_addr = m0_addr_i;
            g_data = m0_data_i;
            g_sel  = m0_sel_i;
        end
    end

    // Outputs are forced low while rst is high so a transfer in flight is
    // dropped immediately rather than one edge later.
    assign out_busy    = (state_q == ST_BUSY) && !rst;
    // A master that lets go of cyc_i forfeits any ack or err in that cycle.
    assign g_active    = (state_q == ST_BUSY) && g_cyc;
    assign ack_hit     = g_active && s_ack_i;
    // Ack takes priority over a coinciding timeout.
    assign timeout_hit = g_active && !s_ack_i && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (!g_cyc || ack_hit || timeout_hit) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave side mirrors the granted master while BUSY, zero otherwise.
    assign s_cyc_o  = out_busy & g_cyc;
    assign s_stb_o  = out_busy & g_stb;
    assign s_we_o   = out_busy & g_we;
    assign s_addr_o = out_busy ? g_addr : '0;
    assign s_data_o = out_busy ? g_data : '0;
    assign s_sel_o  = out_busy ? g_sel  : '0;

    // Master side: only the granted master ever sees ack, err or data.
    assign m0_ack_o  = !rst && ack_hit && !grant_q;
    assign m1_ack_o  = !rst && ack_hit &&  grant_q;
    assign m0_err_o  = !rst && timeout_hit && !grant_q;
    assign m1_err_o  = !rst && timeout_hit &&  grant_q;
    assign m0_data_o = m0_ack_o ? s_data_i : '0;
    assign m1_data_o = m1_ack_o ? s_data_i : '0;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (TIMEOUT = 4). A transaction-level
// model predicts every output each cycle; directed scenarios add literal
// expectations at the points of interest.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_data_i;
    logic        s_ack_i;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // owner: -1 when no transfer is in progress, else the master being served.
    // age:   which cycle of the current transfer we are in, counting from 1.
    int mdl_owner = -1;
    int mdl_last  = 1;
    int mdl_age   = 0;

    always @(posedge clk) begin
        bit r0, r1, gc;
        r0 = m0_cyc_i && m0_stb_i;
        r1 = m1_cyc_i && m1_stb_i;
        if (rst) begin
            mdl_owner = -1;
            mdl_last  = 1;
            mdl_age   = 0;
        end else if (mdl_owner < 0) begin
            if (r0 && r1)  mdl_owner = (mdl_last == 0) ? 1 : 0;
            else if (r0)   mdl_owner = 0;
            else if (r1)   mdl_owner = 1;
            mdl_age = 1;
        end else begin
            gc = (mdl_owner == 1) ? m1_cyc_i : m0_cyc_i;
            if (!gc || s_ack_i || mdl_age == TO) begin
                mdl_last  = mdl_owner;
                mdl_owner = -1;
            end else begin
                mdl_age++;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        bit          busy, gc, acked, erred;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_sel;
        bit          e_stb, e_we;
        busy   = (mdl_owner >= 0) && !rst;
        gc     = (mdl_owner == 1) ? m1_cyc_i  : m0_cyc_i;
        e_stb  = (mdl_owner == 1) ? m1_stb_i  : m0_stb_i;
        e_we   = (mdl_owner == 1) ? m1_we_i   : m0_we_i;
        e_addr = (mdl_owner == 1) ? m1_addr_i : m0_addr_i;
        e_data = (mdl_owner == 1) ? m1_data_i : m0_data_i;
        e_sel  = (mdl_owner == 1) ? m1_sel_i  : m0_sel_i;
        acked  = busy && gc && s_ack_i;
        erred  = busy && gc && !s_ack_i && (mdl_age == TO);
        check("s_cyc",  32'(s_cyc_o),  32'(busy && gc));
        check("s_stb",  32'(s_stb_o),  32'(busy && e_stb));
        check("s_we",   32'(s_we_o),   32'(busy && e_we));
        check("s_addr", s_addr_o,      busy ? e_addr : 32'h0);
        check("s_data", s_data_o,      busy ? e_data : 32'h0);
        check("s_sel",  32'(s_sel_o),  busy ? 32'(e_sel) : 32'h0);
        check("m0_ack", 32'(m0_ack_o), 32'(acked && mdl_owner == 0));
        check("m1_ack", 32'(m1_ack_o), 32'(acked && mdl_owner == 1));
        check("m0_err", 32'(m0_err_o), 32'(erred && mdl_owner == 0));
        check("m1_err", 32'(m1_err_o), 32'(erred && mdl_owner == 1));
        check("m0_dat", m0_data_o, (acked && mdl_owner == 0) ? s_data_i : 32'h0);
        check("m1_dat", m1_data_o, (acked && mdl_owner == 1) ? s_data_i : 32'h0);
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic m0_req(input bit on, input bit we, input logic [31:0] addr, input logic [31:0] data);
        m0_cyc_i = on; m0_stb_i = on; m0_we_i = we;
        m0_addr_i = addr; m0_data_i = data; m0_sel_i = on ? 4'hF : 4'h0;
    endtask

    task automatic m1_req(input bit on, input bit we, input logic [31:0] addr, input logic [31:0] data);
        m1_cyc_i = on; m1_stb_i = on; m1_we_i = we;
        m1_addr_i = addr; m1_data_i = data; m1_sel_i = on ? 4'hF : 4'h0;
    endtask

    task automatic slave(input bit ack, input logic [31:0] data);
        s_ack_i = ack; s_data_i = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_req(0, 0, 0, 0);
        m1_req(0, 0, 0, 0);
        slave(0, 0);
        next(); next();
        #1 check("rst_stb", 32'(s_stb_o), 32'h0);

        // m0 read of 0x10, slave acks on the third BUSY cycle.
        rst = 1'b0;
        m0_req(1, 0, 32'h10, 0);
        next();
        #1 check("s1_stb", 32'(s_stb_o), 32'h1);
        check("s1_addr", s_addr_o, 32'h10);
        next(); next();
        slave(1, 32'hDEADBEEF);
        #1 check("s1_ack", 32'(m0_ack_o), 32'h1);
        check("s1_data", m0_data_o, 32'hDEADBEEF);
        check("s1_m1d", m1_data_o, 32'h0);
        next();
        m0_req(0, 0, 0, 0); slave(0, 0);
        #1 check("s1_idle", 32'(s_stb_o), 32'h0);

        // Tie right after reset: m0 first, one idle cycle, then m1.
        rst = 1'b1;
        next(); next();
        rst = 1'b0;
        m0_req(1, 0, 32'h100, 0);
        m1_req(1, 0, 32'h200, 0);
        next();
        #1 check("s2_first", s_addr_o, 32'h100);
        slave(1, 32'hA5A5_0001);
        #1 check("s2_ack0", 32'(m0_ack_o), 32'h1);
        next();
        slave(0, 0); m0_req(0, 0, 0, 0);
        #1 check("s2_gap", 32'(s_stb_o), 32'h0);
        next();
        #1 check("s2_second", s_addr_o, 32'h200);
        check("s2_stb", 32'(s_stb_o), 32'h1);
        slave(1, 32'hA5A5_0002);
        #1 check("s2_ack1", 32'(m1_ack_o), 32'h1);
        next();
        slave(0, 0); m1_req(0, 0, 0, 0);

        // m1 write with no ack: err on the 4th BUSY cycle.
        m1_req(1, 1, 32'h20, 32'h55);
        next();
        #1 check("s3_we", 32'(s_we_o), 32'h1);
        check("s3_wdata", s_data_o, 32'h55);
        check("s3_sel", 32'(s_sel_o), 32'hF);
        next(); next();
        #1 check("s3_noerr", 32'(m1_err_o), 32'h0);
        next();
        #1 check("s3_err", 32'(m1_err_o), 32'h1);
        next();
        m1_req(0, 0, 0, 0);
        #1 check("s3_stb", 32'(s_stb_o), 32'h0);
        check("s3_errclr", 32'(m1_err_o), 32'h0);

        // Ack coinciding with timeout: ack wins.
        m0_req(1, 0, 32'h30, 0);
        next(); next(); next(); next();
        slave(1, 32'h1234_5678);
        #1 check("s4_ack", 32'(m0_ack_o), 32'h1);
        check("s4_err", 32'(m0_err_o), 32'h0);
        check("s4_data", m0_data_o, 32'h1234_5678);
        next();
        slave(0, 0); m0_req(0, 0, 0, 0);

        // Reset mid-transfer; the following tie must go to m0 again.
        m1_req(1, 0, 32'h40, 0);
        next(); next();
        rst = 1'b1;
        #1 check("s6_rstb", 32'(s_stb_o), 32'h0);
        next();
        rst = 1'b0;
        m0_req(1, 0, 32'h50, 0);
        #1 check("s6_idle", 32'(s_cyc_o), 32'h0);
        check("s6_m1ack", 32'(m1_ack_o), 32'h0);
        next();
        #1 check("s6_tie", s_addr_o, 32'h50);
        slave(1, 32'h0BAD_F00D);
        next();
        slave(0, 0); m0_req(0, 0, 0, 0); m1_req(0, 0, 0, 0);

        // m0 drops cyc on its 2nd BUSY cycle; the slave ack is discarded.
        m0_req(1, 0, 32'h60, 0);
        next();
        m1_req(1, 0, 32'h70, 0);
        next();
        m0_req(0, 0, 0, 0);
        slave(1, 32'hFFFF_0000);
        #1 check("s5_noack", 32'(m0_ack_o), 32'h0);
        check("s5_noerr", 32'(m0_err_o), 32'h0);
        next();
        slave(0, 0);
        #1 check("s5_idle", 32'(s_stb_o), 32'h0);
        next();
        #1 check("s5_m1", s_addr_o, 32'h70);
        slave(1, 32'h7777_7777);
        #1 check("s5_ack1", 32'(m1_ack_o), 32'h1);
        next();
        slave(0, 0); m1_req(0, 0, 0, 0);
        next(); next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_arbiter
